// File: rtl/range_stack_pkg.sv
//------------------------------------------------------------------------------
// range_stack_pkg
// Default sizing constants and operation decode shared by the range_stack block.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package range_stack_pkg;

  localparam int c_default_word_size = 16;
  localparam int c_default_depth     = 16;

  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_REJECT  = 3'd4
  } op_e;

  // A simultaneous push+pop on an empty stack degrades to a plain push.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_e op;
    op = OP_IDLE;
    if (push && pop && !empty)  op = OP_REPLACE;
    else if (push && !full)     op = OP_PUSH;
    else if (push)              op = OP_REJECT;
    else if (pop && !empty)     op = OP_POP;
    else if (pop)               op = OP_REJECT;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
//------------------------------------------------------------------------------
// stack_mem
// Pair storage: synchronous write, asynchronous read, no reset on the array.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stack_mem #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [2*WORD_SIZE-1:0] i_wdata,
  input  logic [ADDR_W-1:0]      i_raddr,
  output logic [2*WORD_SIZE-1:0] o_rdata
);

  logic [2*WORD_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/range_stack.sv
//------------------------------------------------------------------------------
// range_stack
// LIFO of word pairs with registered top-of-stack and sticky over/underflow.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_stack
  import range_stack_pkg::*;
#(
  parameter int WORD_SIZE = c_default_word_size,
  parameter int DEPTH     = c_default_depth,
  parameter int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_en,
  input  logic                 pop_en,
  input  logic                 clear_err,
  input  logic [WORD_SIZE-1:0] data_in1,
  input  logic [WORD_SIZE-1:0] data_in2,
  output logic [WORD_SIZE-1:0] data_out1,
  output logic [WORD_SIZE-1:0] data_out2,
  output logic [PTR_W-1:0]     stack_pointer,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int               ADDR_W  = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_depth = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_one   = PTR_W'(1);

  logic [PTR_W-1:0]       r_sp;
  logic [2*WORD_SIZE-1:0] r_top;
  logic                   r_ovf;
  logic                   r_unf;

  op_e                    w_op;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_we;
  logic                   w_set_ovf;
  logic                   w_set_unf;
  logic [ADDR_W-1:0]      w_waddr;
  logic [ADDR_W-1:0]      w_raddr;
  logic [2*WORD_SIZE-1:0] w_in_pair;
  logic [2*WORD_SIZE-1:0] w_rd_pair;

  assign w_full    = (r_sp == c_depth);
  assign w_empty   = (r_sp == '0);
  assign w_op      = decode_op(push_en, pop_en, w_full, w_empty);
  assign w_in_pair = {data_in2, data_in1};

  // Storage mirrors every entry including the top, so a pop refills from
  // the slot just below the current top (index sp-2) in the same edge.
  assign w_we      = (w_op == OP_PUSH) || (w_op == OP_REPLACE);
  assign w_waddr   = (w_op == OP_REPLACE) ? (r_sp[ADDR_W-1:0] - ADDR_W'(1))
                                          : r_sp[ADDR_W-1:0];
  assign w_raddr   = r_sp[ADDR_W-1:0] - ADDR_W'(2);
  assign w_set_ovf = (w_op == OP_REJECT) && push_en;
  assign w_set_unf = (w_op == OP_REJECT) && !push_en;

  stack_mem #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_in_pair),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_pair)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp  <= '0;
      r_top <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          r_sp  <= r_sp + c_one;
          r_top <= w_in_pair;
        end
        OP_POP: begin
          r_sp  <= r_sp - c_one;
          r_top <= (r_sp == c_one) ? '0 : w_rd_pair;
        end
        OP_REPLACE: begin
          r_top <= w_in_pair;
        end
        default: begin
        end
      endcase
      // Set wins over a coincident clear.
      r_ovf <= w_set_ovf | (r_ovf & ~clear_err);
      r_unf <= w_set_unf | (r_unf & ~clear_err);
    end
  end

  assign data_out1     = r_top[WORD_SIZE-1:0];
  assign data_out2     = r_top[2*WORD_SIZE-1:WORD_SIZE];
  assign stack_pointer = r_sp;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_range_stack.sv
//------------------------------------------------------------------------------
// tb_range_stack
// Drives a DEPTH=16 and a DEPTH=4 instance in lockstep against a pair-stack model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_range_stack;

  typedef struct packed {
    logic [4:0]  sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
    logic [15:0] d2;
    logic [15:0] d1;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_en = 1'b0;
  logic        pop_en = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] data_in1 = '0;
  logic [15:0] data_in2 = '0;

  logic [15:0] a_o1, a_o2, b_o1, b_o2;
  logic [4:0]  a_sp;
  logic [2:0]  b_sp;
  logic        a_full, a_empty, a_ovf, a_unf;
  logic        b_full, b_empty, b_ovf, b_unf;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] mmem[2][16];
  int          mcnt[2];
  int          mdepth[2] = '{16, 4};
  logic        movf[2];
  logic        munf[2];

  always #5 clk = ~clk;

  range_stack dut16 (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en), .clear_err(clear_err),
    .data_in1(data_in1), .data_in2(data_in2), .data_out1(a_o1), .data_out2(a_o2),
    .stack_pointer(a_sp), .full(a_full), .empty(a_empty), .overflow(a_ovf), .underflow(a_unf)
  );

  range_stack #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en), .clear_err(clear_err),
    .data_in1(data_in1), .data_in2(data_in2), .data_out1(b_o1), .data_out2(b_o2),
    .stack_pointer(b_sp), .full(b_full), .empty(b_empty), .overflow(b_ovf), .underflow(b_unf)
  );

  function automatic exp_t obs(input int k);
    exp_t r;
    if (k == 0) r = {a_sp, a_full, a_empty, a_ovf, a_unf, a_o2, a_o1};
    else        r = {2'b00, b_sp, b_full, b_empty, b_ovf, b_unf, b_o2, b_o1};
    return r;
  endfunction

  function automatic exp_t model_exp(input int k);
    exp_t e;
    int   n;
    n       = mcnt[k];
    e.sp    = 5'(n);
    e.full  = (n == mdepth[k]);
    e.empty = (n == 0);
    e.ovf   = movf[k];
    e.unf   = munf[k];
    if (n == 0) {e.d2, e.d1} = 32'h0;
    else        {e.d2, e.d1} = mmem[k][n-1];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      movf[k] = 1'b0;
      munf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic p, input logic q, input logic c,
                            input logic [15:0] a, input logic [15:0] b);
    int   n;
    logic so, su;
    n  = mcnt[k];
    so = 1'b0;
    su = 1'b0;
    if (p && q && n > 0)          mmem[k][n-1] = {b, a};
    else if (p && n < mdepth[k]) begin
      mmem[k][n] = {b, a};
      mcnt[k]    = n + 1;
    end
    else if (p)                   so = 1'b1;
    else if (q && n > 0)          mcnt[k] = n - 1;
    else if (q)                   su = 1'b1;
    movf[k] = so | (movf[k] & !c);
    munf[k] = su | (munf[k] & !c);
  endtask

  task automatic drive(input logic p, input logic q, input logic c,
                       input logic [15:0] a, input logic [15:0] b);
    push_en = p; pop_en = q; clear_err = c; data_in1 = a; data_in2 = b;
    model_step(0, p, q, c, a, b);
    model_step(1, p, q, c, a, b);
    exp_q0.push_back(model_exp(0));
    exp_q1.push_back(model_exp(1));
    @(posedge clk);
    #1;
    push_en = 1'b0; pop_en = 1'b0; clear_err = 1'b0;
  endtask

  task automatic apply_reset();
    push_en = 1'b0; pop_en = 1'b0; clear_err = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e, got;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      e = model_exp(k); got = obs(k); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected %h", k, got, e);
      end
    end
    // A push while reset is held must be discarded.
    push_en = 1'b1; data_in1 = 16'h1234; data_in2 = 16'h5678;
    @(posedge clk);
    #1;
    push_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = model_exp(k); got = obs(k); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_held_push dut%0d: got %h expected %h", k, got, e);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_lifo();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 1'b0, 16'(22 + 2*i), 16'(23 + 2*i));
      else       drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        got = obs(k); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL lifo step %0d dut%0d: got %h expected %h", i, k, got, e);
        end
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       drive(1'b1, 1'b0, 1'b0, 16'(100 + i), 16'(200 + i));
      else if (i == 5) drive(1'b1, 1'b0, 1'b1, 16'h0AAA, 16'h0BBB);
      else             drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        got = obs(k); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL overflow step %0d dut%0d: got %h expected %h", i, k, got, e);
        end
      end
    end
  endtask

  task automatic test_underflow();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        1:       drive(1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
        2:       drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        3:       drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        default: drive(1'b1, 1'b0, 1'b0, 16'h0009, 16'h000A);
      endcase
      for (int k = 0; k < 2; k++) begin
        if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        got = obs(k); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL underflow step %0d dut%0d: got %h expected %h", i, k, got, e);
        end
      end
    end
  endtask

  task automatic test_replace();
    exp_t        e, got;
    logic [2:0]  op_p, op_q;
    logic [15:0] va [10];
    op_p = 3'b0; op_q = 3'b0;
    va = '{16'd7, 16'd10, 16'd22, 16'd40, 16'd0, 16'd1, 16'd3, 16'd50, 16'd0, 16'd0};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      // Sequence: pp(empty), push, push, pp, pop, push, push, pp(full on dut4), pop, pop
      case (i)
        0, 3, 7: begin op_p[0] = 1'b1; op_q[0] = 1'b1; end
        4, 8, 9: begin op_p[0] = 1'b0; op_q[0] = 1'b1; end
        default: begin op_p[0] = 1'b1; op_q[0] = 1'b0; end
      endcase
      drive(op_p[0], op_q[0], 1'b0, va[i], va[i] + 16'd1);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        got = obs(k); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL replace step %0d dut%0d: got %h expected %h", i, k, got, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      if (i < 16) drive(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      else        drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        got = obs(k); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL back_to_back step %0d dut%0d: got %h expected %h", i, k, got, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0022);
    drive(1'b1, 1'b0, 1'b0, 16'h0033, 16'h0044);
    void'(exp_q0.pop_front()); void'(exp_q0.pop_front());
    void'(exp_q1.pop_front()); void'(exp_q1.pop_front());
    for (int k = 0; k < 2; k++) begin
      got = obs(k); checks++;
      if (got.sp !== 5'd2) begin
        errors++;
        $display("FAIL mid_reset_setup dut%0d: got sp %0d expected 2", k, got.sp);
      end
    end
    push_en = 1'b1; data_in1 = 16'h0055; data_in2 = 16'h0066;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      e = model_exp(k); got = obs(k); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_reset_async dut%0d: got %h expected %h", k, got, e);
      end
    end
    @(posedge clk);
    #1;
    push_en = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
      got = obs(k); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_reset_pop dut%0d: got %h expected %h", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/range_stack.md
RANGE_STACK -- requirements
Module: range_stack

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of entry pairs held; SHALL be a power of two and at least 2.
REQ-003 Parameter PTR_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 push_en  input  1  push the pair {data_in1, data_in2} this cycle.
REQ-007 pop_en  input  1  pop the top pair this cycle.
REQ-008 clear_err  input  1  synchronous clear of the sticky error flags.
REQ-009 data_in1  input  WORD_SIZE  first word of the pushed pair (low index).
REQ-010 data_in2  input  WORD_SIZE  second word of the pushed pair (high index).
REQ-011 data_out1  output  WORD_SIZE  first word of the current top pair (registered).
REQ-012 data_out2  output  WORD_SIZE  second word of the current top pair (registered).
REQ-013 stack_pointer  output  PTR_W  number of valid pairs, 0..DEPTH.
REQ-014 full  output  1  high when stack_pointer == DEPTH.
REQ-015 empty  output  1  high when stack_pointer == 0.
REQ-016 overflow  output  1  sticky; set by a rejected push.
REQ-017 underflow  output  1  sticky; set by a rejected pop.

Function
REQ-018 Push only, not full: the pair is written at index stack_pointer; stack_pointer increments; data_out1/2 equal the new pair on the following cycle.
REQ-019 Pop only, not empty: stack_pointer decrements; data_out1/2 show the pair at the new top on the following cycle, or 0/0 if the stack is now empty.
REQ-020 Push and pop together, not empty: the top pair is replaced by the input pair; stack_pointer is unchanged; data_out1/2 show the input pair on the following cycle.
REQ-021 Push and pop together, empty: treated as push only; underflow is not set.
REQ-022 Push only, full: the push is ignored, state is unchanged, and overflow is set.
REQ-023 Push and pop together, full: treated as a replace per REQ-020; overflow is not set.
REQ-024 Pop only, empty: the pop is ignored, state is unchanged, and underflow is set.
REQ-025 While empty is high, data_out1/2 are 0.
REQ-026 The top pair is held in dedicated registers; entries below the top are held in storage. A pop refills the top registers from storage in the same edge, with no bubble cycle.
REQ-027 full and empty are decoded from stack_pointer registered state, with no input-to-output combinational path.
REQ-028 clear_err clears overflow and underflow at the next edge. If clear_err coincides with a new error event, the flag remains set (set has priority).
REQ-029 Back-to-back operations on every cycle are supported; throughput is one operation per clock.
REQ-030 stack_pointer never wraps: no value above DEPTH and no underflow below 0 is ever produced.

Reset
REQ-031 When reset is low: stack_pointer=0, data_out1=0, data_out2=0, overflow=0, underflow=0, full=0, empty=1, regardless of clk.
REQ-032 Storage contents need not be cleared; they SHALL never be observable after reset until rewritten.
REQ-033 Reset asserted mid-operation discards any push or pop in that cycle. The first operation after deassertion acts on an empty stack.

Structure
REQ-034 Package range_stack_pkg SHALL hold the default WORD_SIZE/DEPTH constants and an op-decode enum: OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE, OP_REJECT.
REQ-035 The sub-module stack_mem SHALL implement the pair storage as a synchronous-write, asynchronous-read, 2*WORD_SIZE-wide, DEPTH-deep array; range_stack owns the pointer, top registers and flags.

Verification
REQ-036 Reset, then push (22,23),(24,25),(26,27) -> stack_pointer 3; data_out 26/27; pop x3 -> outputs 24/25, 22/23, then 0/0 with empty=1.
REQ-037 DEPTH=4: push 5 pairs -> stack_pointer 4, full=1, overflow=1 after the fifth push; top pair unchanged.
REQ-038 From empty, pop -> underflow=1, stack_pointer 0; then clear_err -> underflow=0 next cycle.
REQ-039 With (22,23) on top, push and pop together with (40,41) -> stack_pointer unchanged; data_out 40/41; then pop reveals the previous second entry.
REQ-040 Push on every cycle for DEPTH cycles, then pop on every cycle -> LIFO order exact; no bubble cycle; empty=1 after the last pop.
REQ-041 Assert reset mid-push with stack_pointer=2 -> all outputs at reset values immediately; a following pop sets underflow.
